// File: rtl/alu_issue.sv
// Issue/capture front end for the combinational ALU: one request in, fixed settle window, one response out.
// Define ALU_ISSUE_MULDIV_EN to make mul (2) and div (3) legal; otherwise they are rejected as illegal ops.
module alu_issue #(
    parameter int DATA_W      = 32,
    parameter int MULDIV_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [3:0]        req_tag,
    output logic [DATA_W-1:0] alu_inA,
    output logic [DATA_W-1:0] alu_inB,
    output logic [3:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic [3:0]        rsp_tag,
    input  logic              clear_sticky,
    output logic              status_ovf_sticky
);
    localparam int CW = (MULDIV_WAIT < 2) ? 1 : $clog2(MULDIV_WAIT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [3:0]          op_q;
    logic [3:0]          tag_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   res_q;
    logic                zero_q;
    logic                ovf_q;
    logic                err_q;
    logic                ready_q;
    logic                valid_q;
    logic                sticky_q;

    logic                op_legal;
    logic                op_muldiv;
    logic                div_zero;
    logic                ovf_defined;

    always_comb begin
`ifdef ALU_ISSUE_MULDIV_EN
        op_legal  = (req_op <= 4'd5);
        op_muldiv = (req_op == 4'd2) || (req_op == 4'd3);
`else
        op_legal  = (req_op == 4'd0) || (req_op == 4'd1) || (req_op == 4'd4) || (req_op == 4'd5);
        op_muldiv = 1'b0;
`endif
        div_zero    = op_legal && (req_op == 4'd3) && (req_b == '0);
        // ALU overflow is meaningless for logic ops and mul, so it is masked for those.
        ovf_defined = (op_q == 4'd0) || (op_q == 4'd1) || (op_q == 4'd3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (clear_sticky) sticky_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        tag_q   <= req_tag;
                        ready_q <= 1'b0;
                        // Rejected requests never reach the ALU, so its inputs keep the previous values.
                        if (!op_legal || div_zero) begin
                            res_q   <= '0;
                            zero_q  <= 1'b1;
                            ovf_q   <= div_zero;
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            op_q    <= req_op;
                            a_q     <= req_a;
                            b_q     <= req_b;
                            cnt_q   <= op_muldiv ? CW'(MULDIV_WAIT) : CW'(1);
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        res_q   <= alu_result;
                        zero_q  <= alu_zero;
                        ovf_q   <= ovf_defined & alu_overflow;
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                        if (ovf_q) sticky_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready         = ready_q;
    assign alu_inA           = a_q;
    assign alu_inB           = b_q;
    assign alu_func          = op_q;
    assign rsp_valid         = valid_q;
    assign rsp_result        = res_q;
    assign rsp_zero          = zero_q;
    assign rsp_overflow      = ovf_q;
    assign rsp_err           = err_q;
    assign rsp_tag           = tag_q;
    assign status_ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU; expectations follow ALU_ISSUE_MULDIV_EN.
module tb_alu_issue;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic [3:0]    req_tag = '0;
    logic [DW-1:0] alu_inA, alu_inB, alu_result;
    logic [3:0]    alu_func;
    logic          alu_overflow, alu_zero;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero, rsp_overflow, rsp_err;
    logic [3:0]    rsp_tag;
    logic          clear_sticky = 1'b0;
    logic          status_ovf_sticky;

    int n_chk = 0;
    int n_fail = 0;
    logic sticky_m = 1'b0;

    typedef struct {
        logic [DW-1:0] res;
        logic          z;
        logic          o;
        logic          e;
        logic [3:0]    tag;
        int            lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_issue #(.DATA_W(DW), .MULDIV_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_func(alu_func),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
        .rsp_tag(rsp_tag), .clear_sticky(clear_sticky), .status_ovf_sticky(status_ovf_sticky)
    );

    // Behavioural ALU; reports junk overflow on ops where it is undefined so masking is visible.
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_func)
            4'd0: begin
                alu_result   = alu_inA + alu_inB;
                alu_overflow = (alu_inA[DW-1] == alu_inB[DW-1]) && (alu_result[DW-1] != alu_inA[DW-1]);
            end
            4'd1: begin
                alu_result   = alu_inA - alu_inB;
                alu_overflow = (alu_inA[DW-1] != alu_inB[DW-1]) && (alu_result[DW-1] != alu_inA[DW-1]);
            end
            4'd2: begin alu_result = alu_inA * alu_inB; alu_overflow = 1'b1; end
            4'd3: alu_result = (alu_inB == '0) ? '0 : DW'($signed(alu_inA) / $signed(alu_inB));
            4'd4: begin alu_result = alu_inA & alu_inB; alu_overflow = 1'b1; end
            4'd5: begin alu_result = alu_inA | alu_inB; alu_overflow = 1'b1; end
            default: ;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic txn(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] tag, input logic [DW-1:0] r, input logic z,
                       input logic o, input logic e, input int lat, input int hold, input logic clr);
        exp_t x;
        int   n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        x.res = r; x.z = z; x.o = o; x.e = e; x.tag = tag; x.lat = lat;
        sbq.push_back(x);
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 100) begin
            chk("alu_inA_hold", 64'(alu_inA), 64'(a));
            chk("alu_inB_hold", 64'(alu_inB), 64'(b));
            chk("alu_func_hold", 64'(alu_func), 64'(op));
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(lat));
        if (sbq.size() == 0) begin
            chk("sb_nonempty", 64'(0), 64'(1));
            return;
        end
        x = sbq.pop_front();
        chk("rsp_result", 64'(rsp_result), 64'(x.res));
        chk("rsp_zero", 64'(rsp_zero), 64'(x.z));
        chk("rsp_overflow", 64'(rsp_overflow), 64'(x.o));
        chk("rsp_err", 64'(rsp_err), 64'(x.e));
        chk("rsp_tag", 64'(rsp_tag), 64'(x.tag));
        chk("req_ready_busy", 64'(req_ready), 64'(0));
        repeat (hold) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_result", 64'(rsp_result), 64'(x.res));
            chk("bp_tag", 64'(rsp_tag), 64'(x.tag));
            chk("bp_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        clear_sticky = clr;
        @(negedge clk);
        clear_sticky = 1'b0;
        if (x.o) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        chk("sticky", 64'(status_ovf_sticky), 64'(sticky_m));
        chk("req_ready_after", 64'(req_ready), 64'(1));
        chk("rsp_valid_after", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_alu_func", 64'(alu_func), 64'(0));
        chk("rst_sticky", 64'(status_ovf_sticky), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 64'(req_ready), 64'(1));

        txn(4'd0, 32'h7FFF_FFFF, 32'h1, 4'd5, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2, 0, 1'b0);
        txn(4'd1, 32'd7, 32'd7, 4'd1, 32'h0, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0);
        txn(4'd0, 32'h8000_0000, 32'h8000_0000, 4'd2, 32'h0, 1'b1, 1'b1, 1'b0, 2, 0, 1'b1);
        txn(4'd4, 32'hF0F0, 32'h0F0F, 4'd3, 32'h0, 1'b1, 1'b0, 1'b0, 2, 0, 1'b1);
        txn(4'd5, 32'h1200, 32'h34, 4'd4, 32'h1234, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);
        txn(4'd1, 32'h8000_0000, 32'h1, 4'd6, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2, 0, 1'b0);
        clear_sticky = 1'b1;
        @(negedge clk);
        clear_sticky = 1'b0;
        sticky_m = 1'b0;
        chk("sticky_clear", 64'(status_ovf_sticky), 64'(0));
`ifdef ALU_ISSUE_MULDIV_EN
        txn(4'd2, 32'd6, 32'd7, 4'd7, 32'd42, 1'b0, 1'b0, 1'b0, MW + 1, 0, 1'b0);
        txn(4'd2, 32'h1_0000, 32'h1_0000, 4'd8, 32'h0, 1'b1, 1'b0, 1'b0, MW + 1, 0, 1'b0);
        txn(4'd3, 32'hFFFF_FFD6, 32'd7, 4'd9, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0, MW + 1, 0, 1'b0);
        txn(4'd3, 32'd7, 32'd0, 4'd10, 32'h0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0);
`else
        txn(4'd2, 32'd6, 32'd7, 4'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
        chk("no_func2", 64'(alu_func == 4'd2), 64'(0));
        txn(4'd3, 32'd7, 32'd0, 4'd10, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
        chk("no_func3", 64'(alu_func == 4'd3), 64'(0));
`endif
        txn(4'd9, 32'd1, 32'd2, 4'd11, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
        txn(4'd15, 32'd1, 32'd2, 4'd12, 32'h0, 1'b1, 1'b0, 1'b1, 1, 3, 1'b0);
        txn(4'd0, 32'd3, 32'd4, 4'd13, 32'd7, 1'b0, 1'b0, 1'b0, 2, 10, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] a, b, r;
            logic [3:0]    op;
            logic          o;
            a = $urandom(); b = $urandom();
            op = (i % 2 == 0) ? 4'd0 : 4'd1;
            r = (op == 4'd0) ? a + b : a - b;
            o = (op == 4'd0) ? ((a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]))
                             : ((a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]));
            txn(op, a, b, 4'(i), r, r == '0, o, 1'b0, 2, i % 3, 1'b0);
        end

        // Reset while a request is in EXEC: it must vanish without a response.
        @(negedge clk);
        req_valid = 1'b1; req_tag = 4'd14; req_a = 32'd6; req_b = 32'd7;
`ifdef ALU_ISSUE_MULDIV_EN
        req_op = 4'd2;
`else
        req_op = 4'd0;
`endif
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        chk("mid_rst_inA", 64'(alu_inA), 64'(0));
        chk("mid_rst_inB", 64'(alu_inB), 64'(0));
        chk("mid_rst_func", 64'(alu_func), 64'(0));
        chk("mid_rst_tag", 64'(rsp_tag), 64'(0));
        chk("mid_rst_sticky", 64'(status_ovf_sticky), 64'(0));
        sticky_m = 1'b0;
        rst_n = 1'b1;
        repeat (MW + 2) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        chk("post_rst_ready", 64'(req_ready), 64'(1));
        txn(4'd0, 32'd1, 32'd1, 4'd15, 32'd2, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
